// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared types, compare-mode constants and element ordering helper
package bitonic_pkg;

  localparam int TYPE_UINT = 0;
  localparam int TYPE_SINT = 1;
  localparam int ELEM_MAX  = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Operands arrive already widened to ELEM_MAX (sign- or zero-extended by the caller).
  function automatic logic elem_lt(input logic [ELEM_MAX-1:0] a,
                                   input logic [ELEM_MAX-1:0] b,
                                   input int                  typ);
    if (typ == TYPE_SINT) return $signed(a) < $signed(b);
    else                  return a < b;
  endfunction

endpackage

// File: rtl/sort_result_reader_if.sv
// rtl/sort_result_reader_if.sv - SRAM read port plus serialised element stream
interface sort_result_reader_if #(
  parameter int WIDTH = 4,
  parameter int BITS  = 8,
  parameter int ADDR  = 10
);
  logic                    read_en;
  logic [ADDR-1:0]         read_addr;
  logic [WIDTH*BITS-1:0]   read_data;
  logic                    elem_valid;
  logic                    elem_ready;
  logic [BITS-1:0]         elem_data;
  logic                    elem_last;

  modport master (
    output read_en, read_addr, elem_valid, elem_data, elem_last,
    input  read_data, elem_ready
  );

  modport slave (
    input  read_en, read_addr, elem_valid, elem_data, elem_last,
    output read_data, elem_ready
  );
endinterface

// File: rtl/sort_elem_cmp.sv
// rtl/sort_elem_cmp.sv - previous-element register and ordering comparator
module sort_elem_cmp
  import bitonic_pkg::*;
#(
  parameter int BITS = 8,
  parameter int TYPE = TYPE_UINT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            xfer_i,
  input  logic [BITS-1:0] data_i,
  input  logic            sticky_i,
  output logic            viol_o,
  output logic            capture_o
);

  logic [BITS-1:0] prev_q;
  logic            have_prev_q;

  function automatic logic [ELEM_MAX-1:0] widen(input logic [BITS-1:0] v);
    if (TYPE == TYPE_SINT) return {{(ELEM_MAX-BITS){v[BITS-1]}}, v};
    else                   return {{(ELEM_MAX-BITS){1'b0}}, v};
  endfunction

  assign viol_o    = xfer_i && have_prev_q && elem_lt(widen(data_i), widen(prev_q), TYPE);
  assign capture_o = viol_o && !sticky_i;

  // have_prev_q spans row boundaries so the first lane of a row is checked against the previous row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else if (clear_i) begin
      have_prev_q <= 1'b0;
    end else if (xfer_i) begin
      prev_q      <= data_i;
      have_prev_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sort_result_reader.sv
// rtl/sort_result_reader.sv - reads sorted SRAM rows, streams elements, checks order
module sort_result_reader
  import bitonic_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BITS  = 8,
  parameter int ADDR  = 10,
  parameter int TYPE  = TYPE_UINT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR-1:0]               start_addr,
  input  logic [ADDR:0]                 row_count,
  output logic                          busy,
  output logic                          done,
  output logic                          order_err,
  output logic [ADDR+$clog2(WIDTH)-1:0] err_index,
  sort_result_reader_if.master          bus
);

  localparam int LW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDXW = ADDR + $clog2(WIDTH);

  state_e                state_q, state_d;
  logic [ADDR-1:0]       addr_q;
  logic [ADDR:0]         rows_left_q;
  logic [ADDR-1:0]       row_idx_q;
  logic [LW-1:0]         lane_q;
  logic [WIDTH*BITS-1:0] buf_q;
  logic                  order_err_q;
  logic [IDXW-1:0]       err_index_q;

  logic            run_start, last_lane, last_row, xfer, viol, capture;
  logic [BITS-1:0] cur_elem;
  logic [IDXW-1:0] elem_idx;

  assign run_start = (state_q == ST_IDLE) && start && (row_count != '0);
  assign last_lane = (lane_q == LW'(WIDTH - 1));
  assign last_row  = (rows_left_q == (ADDR+1)'(1));
  assign cur_elem  = buf_q[int'(lane_q)*BITS +: BITS];
  assign xfer      = (state_q == ST_STREAM) && bus.elem_ready;
  assign elem_idx  = IDXW'(row_idx_q) * IDXW'(WIDTH) + IDXW'(lane_q);

  sort_elem_cmp #(.BITS(BITS), .TYPE(TYPE)) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (run_start),
    .xfer_i    (xfer),
    .data_i    (cur_elem),
    .sticky_i  (order_err_q),
    .viol_o    (viol),
    .capture_o (capture)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = (row_count == '0) ? ST_DONE : ST_READ;
      ST_READ:   state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_STREAM;
      ST_STREAM: if (xfer && last_lane) state_d = last_row ? ST_DONE : ST_READ;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.read_en    = (state_q == ST_READ);
    bus.read_addr  = addr_q;
    bus.elem_valid = (state_q == ST_STREAM);
    bus.elem_data  = (state_q == ST_STREAM) ? cur_elem : '0;
    bus.elem_last  = (state_q == ST_STREAM) && last_lane && last_row;
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
    order_err      = order_err_q;
    err_index      = err_index_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      rows_left_q <= '0;
      row_idx_q   <= '0;
      lane_q      <= '0;
      buf_q       <= '0;
      order_err_q <= 1'b0;
      err_index_q <= '0;
    end else begin
      if (run_start) begin
        addr_q      <= start_addr;
        rows_left_q <= row_count;
        row_idx_q   <= '0;
        order_err_q <= 1'b0;
        err_index_q <= '0;
      end
      if (state_q == ST_LOAD) begin
        buf_q  <= bus.read_data;
        lane_q <= '0;
      end
      if (xfer) begin
        lane_q <= lane_q + LW'(1);
        // Address wraps naturally at 2^ADDR.
        if (last_lane && !last_row) begin
          addr_q      <= addr_q + ADDR'(1);
          rows_left_q <= rows_left_q - (ADDR+1)'(1);
          row_idx_q   <= row_idx_q + ADDR'(1);
        end
      end
      if (viol)    order_err_q <= 1'b1;
      if (capture) err_index_q <= elem_idx;
    end
  end

endmodule

// File: doc/sort_result_reader.md
# sort_result_reader

Read-back engine for the bitonic sorter's output buffer. After the sorter has written sorted rows into SRAM, this block reads a run of rows through the SRAM's synchronous read port. It serialises each row into a single-element valid/ready stream. It also checks in-line that the whole stream is non-decreasing, and flags the first violation.

## Interface
- WIDTH, 4: elements per SRAM row
- BITS, 8: bits per element
- ADDR, 10: SRAM address width
- TYPE, 0: element compare mode; 0 = unsigned, 1 = signed two's complement (other values illegal)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin read-back; sampled only in IDLE
- start_addr  in  ADDR  first row address
- row_count  in  ADDR+1  number of rows to read, 0..2^ADDR
- read_en  out  1  SRAM read strobe, one cycle per row
- read_addr  out  ADDR  SRAM row address
- read_data  in  WIDTH*BITS  SRAM row; valid the cycle after read_en; lane i = bits [i*BITS +: BITS]
- elem_valid  out  1  element available
- elem_ready  in  1  downstream accepts
- elem_data  out  BITS  current element
- elem_last  out  1  final element of the run
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- order_err  out  1  sticky ordering violation
- err_index  out  ADDR+$clog2(WIDTH)  run-relative index of the first violating element

## Operation
- The FSM has five states: IDLE, READ, LOAD, STREAM, DONE.
- **IDLE**
  - start=1 and row_count>0: latch the address and count, clear order_err and err_index, go to READ.
  - start=1 and row_count=0: go directly to DONE; no read is issued.
- **READ:** read_en=1 and read_addr=current row address for one cycle; go to LOAD.
- **LOAD:** capture read_data into the row buffer; clear the lane counter; go to STREAM.
- **STREAM:**
  - elem_valid=1 and elem_data=buffer[lane], emitted lane 0 first.
  - A transfer occurs when elem_valid & elem_ready; on each transfer the lane counter increments.
  - On a transfer of lane WIDTH-1: if rows remain, increment the row address and go to READ; otherwise go to DONE.
- **DONE:** done=1 for one cycle; go to IDLE.
- **Outputs:**
  - busy = (state != IDLE).
  - elem_last = 1 on the lane WIDTH-1 element of the final row.
- **Order check:**
  - Each transferred element except the first of the run is compared with the previously transferred element, using the TYPE rule.
  - If the current element is less than the previous one and order_err=0: set order_err and load err_index with the run-relative element index (row*WIDTH + lane).
  - Later violations are ignored. Streaming never stops on error.
- **Address arithmetic:** row address increments modulo 2^ADDR, so it wraps from 2^ADDR-1 to 0.
- **start outside IDLE:** ignored, including during DONE.
- **Reset:** rst at any time, including mid-run, returns every register to its reset value on the next evaluation. There is no pending state and no partial stream resumption.
- **Reset values:** state=IDLE; read_en, elem_valid, elem_last, busy, done, order_err = 0; read_addr, elem_data, err_index = 0.

## Timing
- Cycle numbering: start high in cycle 0; READ is cycle 1; LOAD is cycle 2; the first elem_valid is cycle 3.
- Per row: 2 overhead cycles plus WIDTH transfer cycles with elem_ready held high.
- elem_data and elem_last stay stable while elem_valid=1 and elem_ready=0.
- order_err and err_index update in the cycle after the violating transfer.
- done is asserted in the cycle after the final transfer; busy falls one cycle after done.
- row_count=0: done in cycle 1; busy is high only in cycle 1.
- read_en is driven from registered state only; no input reaches it combinationally.

## Structure
- The shared package bitonic_pkg holds:
  - the TYPE encoding constants (TYPE_UINT=0, TYPE_SINT=1);
  - the FSM state enum;
  - the function elem_lt(a, b, type) used by both the sorter and this block.
- One sub-module, sort_elem_cmp: a registered previous-element holder plus comparator that produces the violation strobe and index capture enable.
- The FSM, counters and row buffer live in the top module.

## Test plan
- **Reset:** assert rst mid-STREAM → all outputs 0 in that cycle; no read_en afterwards until the next start.
- **Ascending run:**
  - Stimulus: rows {1,2,3,4} at addr 0 and {5,6,7,8} at addr 1; start_addr=0, row_count=2; elem_ready=1.
  - Required: read_en in cycles 1 and 7; elements 1–4 in cycles 3–6 and 5–8 in cycles 9–12; elem_last with value 8; done in cycle 13; order_err=0.
- **Cross-row violation:**
  - Stimulus: rows {1,2,3,9} and {5,6,7,8}.
  - Required: order_err=1 and err_index=4 after the transfer of 5; all 8 elements are still delivered.
- **Backpressure:** elem_ready toggles 1,0,0,1,… → each element is held stable while stalled; transfer count is 8; order_err=0.
- **Empty run and wrap:**
  - row_count=0 → done in cycle 1 and no read_en.
  - start_addr=1023, row_count=2 → read_addr is 1023, then 0.
- **Signed mode:** TYPE=1, row {0xFD,0xFF,0x00,0x02} → order_err=0. The same row with TYPE=0 → order_err=1 and err_index=2.
